// File: rtl/opf_pkg.sv
// Shared pairing-state encoding and parameter defaults for operand_pair_fifo.
package opf_pkg;

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } pair_state_t;

    localparam int unsigned OPF_WIDTH_DEFAULT = 16;
    localparam int unsigned OPF_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/opf_pair_ram.sv
// Pair storage for operand_pair_fifo: DEPTH x 2*WIDTH, one write port, async read.
module opf_pair_ram
    import opf_pkg::*;
#(
    parameter  int unsigned WIDTH = OPF_WIDTH_DEFAULT,
    parameter  int unsigned DEPTH = OPF_DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [2*WIDTH-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [2*WIDTH-1:0] rd_data
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/operand_pair_fifo.sv
// Pairs a serial operand stream into {first, second} entries held in a FWFT FIFO.
// Optional macro OPF_COUNT_EN adds the Count output.
module operand_pair_fifo
    import opf_pkg::*;
#(
    parameter  int unsigned WIDTH = OPF_WIDTH_DEFAULT,
    parameter  int unsigned DEPTH = OPF_DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In_Num,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Target_In,
    input  logic             Target_Load,
    output logic [WIDTH-1:0] First_Num,
    output logic [WIDTH-1:0] Second_Num,
    output logic [WIDTH-1:0] Target_Num,
    output logic             Out_Valid,
`ifdef OPF_COUNT_EN
    output logic [CW-1:0]    Count,
`endif
    input  logic             Out_Ready
);

    pair_state_t        state;
    logic [WIDTH-1:0]   hold;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_next;
    logic [AW-1:0]      rd_next;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic [2*WIDTH-1:0] head;
    logic [2*WIDTH-1:0] head_next;
    logic [2*WIDTH-1:0] ram_rd;
    logic [2*WIDTH-1:0] pair_word;
    logic               ready_en;
    logic               accept;
    logic               push;
    logic               pop;

    // ready_en holds In_Ready low until the first edge after Reset releases.
    assign In_Ready  = ready_en && !Target_Load && (count < CW'(DEPTH));
    assign accept    = In_Valid && In_Ready;
    assign push      = accept && (state == WAIT_SECOND);
    assign pop       = Out_Valid && Out_Ready && !Target_Load;
    assign pair_word = {hold, In_Num};

    assign Out_Valid  = (count != '0);
    assign First_Num  = head[2*WIDTH-1:WIDTH];
    assign Second_Num = head[WIDTH-1:0];

`ifdef OPF_COUNT_EN
    assign Count = count;
`endif

    always_comb begin
        rd_next    = rd_ptr;
        wr_next    = wr_ptr;
        count_next = count;
        if (pop) begin
            rd_next = rd_ptr + 1'b1;
        end
        if (push) begin
            wr_next = wr_ptr + 1'b1;
        end
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    opf_pair_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (Clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (pair_word),
        .rd_addr (rd_next),
        .rd_data (ram_rd)
    );

    // The head register is preloaded with the entry that will be at the head after
    // this edge; when that entry is the one being written now, take it from the input.
    assign head_next = (push && (rd_next == wr_ptr)) ? pair_word : ram_rd;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= WAIT_FIRST;
            hold       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            Target_Num <= '0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (Target_Load) begin
                Target_Num <= Target_In;
                state      <= WAIT_FIRST;
                hold       <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
            end else begin
                if (accept) begin
                    case (state)
                        WAIT_FIRST: begin
                            hold  <= In_Num;
                            state <= WAIT_SECOND;
                        end
                        WAIT_SECOND: begin
                            state <= WAIT_FIRST;
                        end
                        default: begin
                            state <= WAIT_FIRST;
                        end
                    endcase
                end
                wr_ptr <= wr_next;
                rd_ptr <= rd_next;
                count  <= count_next;
                if (count_next != '0) begin
                    head <= head_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_pair_fifo.sv
// Directed, table-driven bench for operand_pair_fifo (WIDTH=16, DEPTH=8).
module tb_operand_pair_fifo;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic [WIDTH-1:0] In_Num = '0;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic [WIDTH-1:0] Target_In = '0;
    logic             Target_Load = 1'b0;
    logic [WIDTH-1:0] First_Num;
    logic [WIDTH-1:0] Second_Num;
    logic [WIDTH-1:0] Target_Num;
    logic             Out_Valid;
    logic             Out_Ready = 1'b0;
`ifdef OPF_COUNT_EN
    logic [CW-1:0]    Count;
`endif

    int checks   = 0;
    int failures = 0;

    operand_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .In_Num      (In_Num),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .Target_In   (Target_In),
        .Target_Load (Target_Load),
        .First_Num   (First_Num),
        .Second_Num  (Second_Num),
        .Target_Num  (Target_Num),
        .Out_Valid   (Out_Valid),
`ifdef OPF_COUNT_EN
        .Count       (Count),
`endif
        .Out_Ready   (Out_Ready)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        iv;
        logic [15:0] num;
        logic        ordy;
        logic        tl;
        logic [15:0] tin;
        logic        rdy;   // In_Ready before the edge
        logic        ov;    // outputs after the edge
        logic [15:0] f;
        logic [15:0] s;
        logic [15:0] t;
    } vec_t;

    vec_t vecs [10];
    logic [31:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] num, input logic ordy,
                         input logic tl, input logic [15:0] tin);
        In_Valid    = iv;
        In_Num      = num;
        Out_Ready   = ordy;
        Target_Load = tl;
        Target_In   = tin;
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int acc;
        logic [15:0] a;

        vecs[0] = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 16'h0005, 16'h0000};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0005, 16'h0000};
        vecs[3] = '{1'b1, 16'h00A1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0005, 16'h0000};
        vecs[4] = '{1'b1, 16'h00B2, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A1, 16'h00B2, 16'h0000};
        vecs[5] = '{1'b1, 16'h00C3, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A1, 16'h00B2, 16'h0000};
        vecs[6] = '{1'b1, 16'h00D4, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00C3, 16'h00D4, 16'h0000};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h00C3, 16'h00D4, 16'h0000};
        vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h00C3, 16'h00D4, 16'hBEEF};
        vecs[9] = '{1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h00C3, 16'h00D4, 16'hBEEF};

        // Reset state
        #1 Reset = 1'b1;
        #2;
        chk("rst_in_ready", {31'd0, In_Ready}, 32'd0);
        chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_pair", {First_Num, Second_Num}, 32'd0);
        chk("rst_target", {16'd0, Target_Num}, 32'd0);
        tick;
        tick;
        Reset = 1'b0;
        #1;
        chk("ready_before_edge", {31'd0, In_Ready}, 32'd0);
        tick;
        chk("ready_after_edge", {31'd0, In_Ready}, 32'd1);

        // Table-driven basic traffic
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].num, vecs[i].ordy, vecs[i].tl, vecs[i].tin);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, In_Ready}, {31'd0, vecs[i].rdy});
            tick;
            chk($sformatf("v%0d_out_valid", i), {31'd0, Out_Valid}, {31'd0, vecs[i].ov});
            chk($sformatf("v%0d_pair", i), {First_Num, Second_Num}, {vecs[i].f, vecs[i].s});
            chk($sformatf("v%0d_target", i), {16'd0, Target_Num}, {16'd0, vecs[i].t});
        end

        // Fill with Out_Ready low: 2*DEPTH words fit, the rest are refused
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        tick;
        acc = 0;
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            drive(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 16'h0);
            #1;
            if (In_Ready) acc++;
            tick;
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        #1;
        chk("fill_accepted", acc, 2 * DEPTH);
        chk("fill_in_ready", {31'd0, In_Ready}, 32'd0);
        chk("fill_out_valid", {31'd0, Out_Valid}, 32'd1);
        chk("fill_head", {First_Num, Second_Num}, 32'h0100_0101);

        // One pop from full: no same-cycle bypass, ready next cycle
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        #1;
        chk("full_pop_no_bypass", {31'd0, In_Ready}, 32'd0);
        tick;
        chk("after_pop_ready", {31'd0, In_Ready}, 32'd1);
`ifdef OPF_COUNT_EN
        chk("after_pop_count", {{(32-CW){1'b0}}, Count}, DEPTH - 1);
`endif
        for (int k = 1; k < DEPTH; k++) begin
            chk($sformatf("drain%0d_valid", k), {31'd0, Out_Valid}, 32'd1);
            chk($sformatf("drain%0d_pair", k), {First_Num, Second_Num},
                {16'(16'h0100 + 2 * k), 16'(16'h0101 + 2 * k)});
            tick;
        end
        chk("drained_valid", {31'd0, Out_Valid}, 32'd0);
        chk("drained_hold", {First_Num, Second_Num}, 32'h010E_010F);

        // Target_Load in WAIT_SECOND with 3 pairs stored
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 16'(16'h0201 + i), 1'b0, 1'b0, 16'h0);
            tick;
        end
        chk("tl_pre_head", {First_Num, Second_Num}, 32'h0201_0202);
        drive(1'b1, 16'h0999, 1'b1, 1'b1, 16'h1234);
        #1;
        chk("tl_in_ready", {31'd0, In_Ready}, 32'd0);
        tick;
        chk("tl_target", {16'd0, Target_Num}, 32'h0000_1234);
        chk("tl_out_valid", {31'd0, Out_Valid}, 32'd0);
`ifdef OPF_COUNT_EN
        chk("tl_count", {{(32-CW){1'b0}}, Count}, 32'd0);
`endif
        drive(1'b1, 16'h0AAA, 1'b0, 1'b0, 16'h0);
        tick;
        chk("tl_first_word_alone", {31'd0, Out_Valid}, 32'd0);
        drive(1'b1, 16'h0BBB, 1'b0, 1'b0, 16'h0);
        tick;
        chk("tl_next_pair", {First_Num, Second_Num}, 32'h0AAA_0BBB);

        // Reset between the two words of a pair
        drive(1'b1, 16'h0777, 1'b0, 1'b0, 16'h0);
        tick;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, In_Ready}, 32'd0);
        chk("midrst_pair", {First_Num, Second_Num}, 32'd0);
        chk("midrst_target", {16'd0, Target_Num}, 32'd0);
        tick;
        Reset = 1'b0;
        tick;
        drive(1'b1, 16'h0888, 1'b0, 1'b0, 16'h0);
        tick;
        chk("midrst_no_pair", {31'd0, Out_Valid}, 32'd0);
        drive(1'b1, 16'h0999, 1'b0, 1'b0, 16'h0);
        tick;
        chk("midrst_pair_valid", {31'd0, Out_Valid}, 32'd1);
        chk("midrst_next_pair", {First_Num, Second_Num}, 32'h0888_0999);
        q.push_back(32'h0888_0999);

        // Steady push+pop at count=3 across pointer wrap
        for (int i = 0; i < 4; i += 2) begin
            a = 16'(16'h0301 + i);
            drive(1'b1, a, 1'b0, 1'b0, 16'h0);
            tick;
            drive(1'b1, a + 16'd1, 1'b0, 1'b0, 16'h0);
            tick;
            q.push_back({a, a + 16'd1});
        end
        for (int k = 0; k < 10; k++) begin
            a = 16'(16'h0400 + 2 * k);
            drive(1'b1, a, 1'b0, 1'b0, 16'h0);
            tick;
            drive(1'b1, a + 16'd1, 1'b1, 1'b0, 16'h0);
            #1;
            chk($sformatf("wrap%0d_head", k), {First_Num, Second_Num}, q[0]);
            chk($sformatf("wrap%0d_ready", k), {31'd0, In_Ready}, 32'd1);
            tick;
            void'(q.pop_front());
            q.push_back({a, a + 16'd1});
        end
`ifdef OPF_COUNT_EN
        chk("wrap_count", {{(32-CW){1'b0}}, Count}, 32'd3);
`endif
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wrapdrain%0d_valid", k), {31'd0, Out_Valid}, 32'd1);
            chk($sformatf("wrapdrain%0d_pair", k), {First_Num, Second_Num}, q.pop_front());
            tick;
        end
        chk("wrapdrain_empty", {31'd0, Out_Valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
